// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation result path.
// Holds the result-entry layout and the search-position to MV conversion.
package me_pkg;

    localparam int SAD_W     = 14;
    localparam int POS_W     = 5;
    localparam int MV_W      = 6;
    localparam int IDX_MAX_W = 16;

    typedef struct packed {
        logic [MV_W-1:0]      mv_x;
        logic [MV_W-1:0]      mv_y;
        logic [SAD_W-1:0]     sad;
        logic                 skip;
        logic [IDX_MAX_W-1:0] blk_idx;
        logic                 last;
    } mv_entry_t;

    // Zero-extend the window position and subtract the centre in MV_W bits.
    function automatic logic [MV_W-1:0] pos_to_mv(
        input logic [POS_W-1:0] pos,
        input int unsigned      center
    );
        logic [MV_W-1:0] c;
        c = center[MV_W-1:0];
        return {1'b0, pos} - c;
    endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// Synchronous FIFO with registered first-word-fall-through output.
// A push into a full FIFO is accepted only when a pop frees a slot.
module me_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (push_en) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_en) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/me_mv_collector.sv
// Converts ME per-block results into tagged motion vectors and buffers
// them for a backpressured consumer; drops and flags on overflow.
module me_mv_collector
    import me_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter int SEARCH_CENTER    = 8,
    parameter int SKIP_THRESH      = 64,
    parameter int BLOCKS_PER_FRAME = 16,
    parameter int IDX_W            = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid_i,
    input  logic [SAD_W-1:0] MSAD_i,
    input  logic [POS_W-1:0] MSAD_row_i,
    input  logic [POS_W-1:0] MSAD_column_i,
    output logic             mv_valid_o,
    input  logic             mv_ready_i,
    output logic [MV_W-1:0]  mv_x_o,
    output logic [MV_W-1:0]  mv_y_o,
    output logic [SAD_W-1:0] mv_sad_o,
    output logic             mv_skip_o,
    output logic [IDX_W-1:0] mv_blk_idx_o,
    output logic             mv_last_o,
    output logic [CW-1:0]    fifo_count_o,
    output logic             overflow_o
);

    mv_entry_t        in_e, out_e;
    logic [IDX_W-1:0] blk_q, blk_d;
    logic             overflow_q, overflow_d;
    logic             is_last, full, empty;

    assign is_last = (blk_q == IDX_W'(BLOCKS_PER_FRAME - 1));

    always_comb begin
        in_e         = '0;
        in_e.mv_x    = pos_to_mv(MSAD_column_i, SEARCH_CENTER);
        in_e.mv_y    = pos_to_mv(MSAD_row_i, SEARCH_CENTER);
        in_e.sad     = MSAD_i;
        in_e.skip    = ({1'b0, MSAD_i} < (SAD_W + 1)'(SKIP_THRESH));
        in_e.blk_idx = IDX_MAX_W'(blk_q);
        in_e.last    = is_last;
    end

    // The index advances on every result, stored or dropped.
    always_comb begin
        blk_d      = blk_q;
        overflow_d = overflow_q;
        if (data_valid_i) begin
            blk_d = is_last ? '0 : blk_q + 1'b1;
            if (full && !mv_ready_i) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            blk_q      <= blk_d;
            overflow_q <= overflow_d;
        end
    end

    me_sync_fifo #(
        .WIDTH ($bits(mv_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (data_valid_i),
        .pop_i   (mv_ready_i),
        .din_i   (in_e),
        .dout_o  (out_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count_o)
    );

    assign mv_valid_o   = !empty;
    assign mv_x_o       = out_e.mv_x;
    assign mv_y_o       = out_e.mv_y;
    assign mv_sad_o     = out_e.sad;
    assign mv_skip_o    = out_e.skip;
    assign mv_blk_idx_o = out_e.blk_idx[IDX_W-1:0];
    assign mv_last_o    = out_e.last;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_me_mv_collector.sv
// Directed and randomized bench for me_mv_collector against a queue model.
// Model: entries as plain ints in a queue of at most 4, frame of 16 blocks.
module tb_me_mv_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid_i = 1'b0;
    logic [13:0] MSAD_i = '0;
    logic [4:0]  MSAD_row_i = '0;
    logic [4:0]  MSAD_column_i = '0;
    logic        mv_ready_i = 1'b0;
    logic        mv_valid_o;
    logic [5:0]  mv_x_o, mv_y_o;
    logic [13:0] mv_sad_o;
    logic        mv_skip_o;
    logic [7:0]  mv_blk_idx_o;
    logic        mv_last_o;
    logic [2:0]  fifo_count_o;
    logic        overflow_o;

    me_mv_collector dut (
        .clk           (clk),
        .rst           (rst),
        .data_valid_i  (data_valid_i),
        .MSAD_i        (MSAD_i),
        .MSAD_row_i    (MSAD_row_i),
        .MSAD_column_i (MSAD_column_i),
        .mv_valid_o    (mv_valid_o),
        .mv_ready_i    (mv_ready_i),
        .mv_x_o        (mv_x_o),
        .mv_y_o        (mv_y_o),
        .mv_sad_o      (mv_sad_o),
        .mv_skip_o     (mv_skip_o),
        .mv_blk_idx_o  (mv_blk_idx_o),
        .mv_last_o     (mv_last_o),
        .fifo_count_o  (fifo_count_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    typedef struct {
        int x, y, sad, skip, idx, last;
    } ent_t;

    ent_t q[$];
    int   mblk = 0;
    int   movf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sampled on the same edge as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mblk = 0;
            movf = 0;
        end else begin
            bit   pop, full;
            ent_t e;
            pop  = (q.size() > 0) && mv_ready_i;
            full = (q.size() == 4);
            if (pop) void'(q.pop_front());
            if (data_valid_i) begin
                e.x    = int'(MSAD_column_i) - 8;
                e.y    = int'(MSAD_row_i) - 8;
                e.sad  = int'(MSAD_i);
                e.skip = (int'(MSAD_i) < 64) ? 1 : 0;
                e.idx  = mblk;
                e.last = (mblk == 15) ? 1 : 0;
                if (!full || pop) q.push_back(e);
                else movf = 1;
                mblk = (mblk + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", int'(mv_valid_o), (q.size() != 0) ? 1 : 0);
            chk("count", int'(fifo_count_o), q.size());
            chk("overflow", int'(overflow_o), movf);
            if (q.size() != 0) begin
                chk("mv_x", int'($signed(mv_x_o)), q[0].x);
                chk("mv_y", int'($signed(mv_y_o)), q[0].y);
                chk("sad", int'(mv_sad_o), q[0].sad);
                chk("skip", int'(mv_skip_o), q[0].skip);
                chk("blk_idx", int'(mv_blk_idx_o), q[0].idx);
                chk("last", int'(mv_last_o), q[0].last);
            end
        end
    end

    task automatic tick(input logic dv, input int s, input int r,
                        input int c, input logic rdy);
        data_valid_i  = dv;
        MSAD_i        = 14'(s);
        MSAD_row_i    = 5'(r);
        MSAD_column_i = 5'(c);
        mv_ready_i    = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk_en = 1;
        chk("rst_valid", int'(mv_valid_o), 0);
        chk("rst_count", int'(fifo_count_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);

        // Single result, consumer ready
        tick(1, 100, 8, 11, 1);
        chk("s_valid", int'(mv_valid_o), 1);
        chk("s_x", int'(mv_x_o), 3);
        chk("s_y", int'(mv_y_o), 0);
        chk("s_skip", int'(mv_skip_o), 0);
        chk("s_idx", int'(mv_blk_idx_o), 0);
        chk("s_last", int'(mv_last_o), 0);
        tick(0, 0, 0, 0, 1);
        chk("s_drain", int'(fifo_count_o), 0);

        // Negative vectors and the skip threshold edge
        tick(1, 63, 0, 2, 1);
        chk("n_y", int'(mv_y_o), 'h38);
        chk("n_x", int'(mv_x_o), 'h3A);
        chk("n_skip63", int'(mv_skip_o), 1);
        tick(1, 64, 0, 2, 1);
        chk("n_skip64", int'(mv_skip_o), 0);
        chk("n_idx", int'(mv_blk_idx_o), 2);
        tick(0, 0, 0, 0, 1);

        // Backpressure and overflow
        do_reset();
        for (int i = 1; i <= 5; i++) tick(1, i, 8, 8, 0);
        chk("bp_count", int'(fifo_count_o), 4);
        chk("bp_ovf", int'(overflow_o), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("bp_sad", int'(mv_sad_o), i);
            chk("bp_idx", int'(mv_blk_idx_o), i - 1);
            tick(0, 0, 0, 0, 1);
        end
        chk("bp_empty", int'(mv_valid_o), 0);
        tick(1, 9, 8, 8, 0);
        chk("bp_idx5", int'(mv_blk_idx_o), 5);
        chk("bp_ovf_sticky", int'(overflow_o), 1);
        tick(0, 0, 0, 0, 1);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) tick(1, 200 + i, 4, 4, 0);
        chk("fp_full", int'(fifo_count_o), 4);
        tick(1, 300, 4, 4, 1);
        chk("fp_count", int'(fifo_count_o), 4);
        chk("fp_ovf", int'(overflow_o), 0);
        chk("fp_head", int'(mv_sad_o), 201);

        // Frame wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(1, 500 + i, 8, 8, 1);
            if (i == 15) begin
                chk("w_idx15", int'(mv_blk_idx_o), 15);
                chk("w_last15", int'(mv_last_o), 1);
            end
            if (i == 16) begin
                chk("w_idx0", int'(mv_blk_idx_o), 0);
                chk("w_last0", int'(mv_last_o), 0);
            end
        end
        tick(0, 0, 0, 0, 1);

        // Randomized traffic with occasional mid-run reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            tick(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 16383)) >> ($urandom_range(0, 1) * 7),
                 int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0);
        end
        rst = 1'b0;
        tick(0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/me_mv_collector.md
Name: me_mv_collector

Overview:
- Sits directly downstream of ME and consumes its per-block result pulse: MSAD, MSAD_row, MSAD_column, data_valid.
- Converts the best-match search position into a signed motion vector and flags skip-candidate blocks.
- Tags each result with a raster block index and frame-last marker.
- Buffers results in a small FIFO so the entropy/packing stage can apply valid/ready backpressure. ME itself has no backpressure.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- SEARCH_CENTER, 8: search-window position that corresponds to zero motion, in both axes.
- SKIP_THRESH, 64: MSAD strictly below this value marks the block as a skip candidate.
- BLOCKS_PER_FRAME, 16: number of blocks per frame. Sets the block-index wrap point.
- IDX_W, 8: block-index width. Requires BLOCKS_PER_FRAME ≤ 2^IDX_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- data_valid_i  in  1  one-cycle pulse from ME; result fields valid this cycle
- MSAD_i  in  14  minimum SAD for the current block
- MSAD_row_i  in  5  row of best match within the search window
- MSAD_column_i  in  5  column of best match within the search window
- mv_valid_o  out  1  output entry available
- mv_ready_i  in  1  consumer accepts the entry when valid && ready
- mv_x_o  out  6  signed, MSAD_column − SEARCH_CENTER
- mv_y_o  out  6  signed, MSAD_row − SEARCH_CENTER
- mv_sad_o  out  14  MSAD passthrough
- mv_skip_o  out  1  MSAD < SKIP_THRESH
- mv_blk_idx_o  out  IDX_W  raster block index within the frame
- mv_last_o  out  1  entry is the last block of the frame
- fifo_count_o  out  clog2(DEPTH+1)  number of entries held
- overflow_o  out  1  sticky: a result was dropped

Behaviour:
- Reset: all of the following are 0 in the cycle after rst is sampled high:
  - mv_valid_o, fifo_count_o, overflow_o
  - block counter, read/write pointers
  - all data outputs
- Reset mid-operation discards all entries; no partial pop is reported.
- Conversion (combinational on the input, before the FIFO write):
  - mv_x = {1'b0,col} − SEARCH_CENTER, computed in 6-bit two's complement.
  - mv_y uses row the same way.
  - Positions 0..31 map to −8..+23 with the default centre.
  - skip = (MSAD < SKIP_THRESH), unsigned compare.
- Block counter:
  - Increments on every data_valid_i, whether or not the entry is stored, so indices stay aligned with frame position.
  - The stored index is the pre-increment value.
  - last = (index == BLOCKS_PER_FRAME−1); the counter then wraps to 0.
- Push: data_valid_i && (!full || pop_this_cycle).
- Pop: mv_valid_o && mv_ready_i.
- Full with a simultaneous pop: both happen and the count is unchanged.
- Full with no pop:
  - The new entry is dropped and overflow_o is set.
  - overflow_o is cleared only by rst.
  - The counter still advances.
- Empty with push: the entry appears on the outputs the next cycle (registered first-word-fall-through, latency 1). No same-cycle bypass.
- Empty: mv_valid_o = 0. Data outputs hold their last value and are don't-care for checking.
- Output stability: while mv_valid_o && !mv_ready_i, all mv_* outputs are stable.
- fifo_count_o is registered: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package me_pkg:
  - Constants: SAD_W=14, POS_W=5, MV_W=6.
  - Typedef mv_entry_t: {mv_x, mv_y, sad, skip, blk_idx, last}.
  - Function pos_to_mv().
- One sub-module, me_sync_fifo:
  - Generic width/depth synchronous FIFO with push/pop/full/empty/count.
  - Handles registered FWFT output and simultaneous push/pop.
- me_mv_collector holds:
  - conversion logic
  - block counter
  - overflow flag
  - FIFO instance

Test Plan:
- Reset: rst high 2 cycles, then low → mv_valid_o=0, fifo_count_o=0, overflow_o=0.
- Single result with ready=1: pulse MSAD=100, row=8, col=11 → next cycle mv_valid_o=1 with mv_x=+3, mv_y=0, skip=0, blk_idx=0, last=0; popped the same cycle, count returns to 0.
- Negative MV and skip: row=0, col=2, MSAD=63 → mv_y=−8 (6'h38), mv_x=−6 (6'h3A), skip=1. Repeat with MSAD=64 → skip=0.
- Backpressure/overflow: ready=0, 5 pulses with MSAD=1..5:
  - fifo_count_o reaches 4 and overflow_o=1 after the 5th pulse.
  - Then ready=1 drains MSAD 1,2,3,4 with blk_idx 0..3.
  - The next pulse gets blk_idx=5.
- Full with simultaneous push and pop: FIFO full, ready=1, and a pulse in the same cycle → count stays 4, overflow_o stays 0.
- Frame wrap: 17 pulses with ready=1 → the 16th entry has blk_idx=15 and last=1; the 17th has blk_idx=0 and last=0.
